// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
//   fetch_state_t : fetch FSM states (REQ / WAIT / DROP)
//   fetch_entry_t : one queue entry {pc, instr[, fault]}
//   NOP_INSTR     : word substituted for out-of-range fetches
// Optional macro IFETCH_RANGE_CHECK_EN adds the per-entry fault bit.
package ifetch_pkg;

  localparam int DEF_ADDR_W  = 32;
  localparam int DEF_INSTR_W = 32;

  localparam logic [DEF_INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    REQ,
    WAIT,
    DROP
  } fetch_state_t;

  // Entry widths follow the package defaults; the unit's ADDR_W/INSTR_W
  // parameters must be left at these values.
  typedef struct packed {
    logic [DEF_ADDR_W-1:0]  pc;
    logic [DEF_INSTR_W-1:0] instr;
`ifdef IFETCH_RANGE_CHECK_EN
    logic                   fault;
`endif
  } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Bus bundle for the fetch unit: instruction-memory request/response
// channel plus the valid/ready channel toward decode.
//   master : fetch unit side
//   slave  : memory + decode side
// With IFETCH_RANGE_CHECK_EN defined, carries the if_fault sideband.
interface instr_fetch_unit_if #(
  parameter int ADDR_W  = 32,
  parameter int INSTR_W = 32
);
  logic               imem_req_valid;
  logic [ADDR_W-1:0]  imem_req_addr;
  logic               imem_req_ready;
  logic               imem_resp_valid;
  logic [INSTR_W-1:0] imem_resp_data;
  logic               if_valid;
  logic               if_ready;
  logic [ADDR_W-1:0]  if_pc;
  logic [INSTR_W-1:0] if_instr;
`ifdef IFETCH_RANGE_CHECK_EN
  logic               if_fault;
`endif

  modport master (
`ifdef IFETCH_RANGE_CHECK_EN
    output if_fault,
`endif
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_resp_valid, imem_resp_data,
    output if_valid, if_pc, if_instr,
    input  if_ready
  );

  modport slave (
`ifdef IFETCH_RANGE_CHECK_EN
    input  if_fault,
`endif
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_resp_valid, imem_resp_data,
    input  if_valid, if_pc, if_instr,
    output if_ready
  );

endinterface

// File: rtl/ifetch_queue.sv
// Two-entry FIFO of fetch_entry_t with a registered head.
//   clk, rst   : clock, synchronous active-high reset
//   flush      : drop all entries (wins over push/pop)
//   push/din   : write an entry
//   pop        : consume the head; ignored when empty
//   head_valid : head entry present
//   head       : head entry (ent0 register)
//   count      : occupancy 0..2
module ifetch_queue
  import ifetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t din,
  input  logic         pop,
  output logic         head_valid,
  output fetch_entry_t head,
  output logic [1:0]   count
);

  fetch_entry_t ent0, ent1;
  logic [1:0]   cnt;
  logic         do_pop;

  assign do_pop     = pop && (cnt != 2'd0);
  assign head_valid = (cnt != 2'd0);
  assign head       = ent0;
  assign count      = cnt;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      cnt <= 2'd0;
    end else begin
      case ({push, do_pop})
        2'b10: begin
          if (cnt == 2'd0)      ent0 <= din;
          else if (cnt == 2'd1) ent1 <= din;
          if (cnt != 2'd2) cnt <= cnt + 2'd1;
        end
        2'b01: begin
          ent0 <= ent1;
          cnt  <= cnt - 2'd1;
        end
        2'b11: begin
          // occupancy unchanged; new entry lands behind whatever remains
          if (cnt == 2'd1) begin
            ent0 <= din;
          end else begin
            ent0 <= ent1;
            ent1 <= din;
          end
        end
        default: ;
      endcase
    end
  end

  // The fetch credit rule keeps the producer from ever overfilling us.
  a_no_push_full: assert property (@(posedge clk) disable iff (rst || flush)
    !(push && (cnt == 2'd2) && !do_pop))
    else $error("ifetch_queue: push while full");

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage downstream of the PC register. Issues one instruction-memory
// read at a time, buffers returned words in a 2-entry queue toward decode
// and drives the combinational next PC (hold / +4 / redirect target).
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   pc              : current fetch address (registered upstream)
//   next_pc         : combinational next value for the PC register
//   redirect_valid  : redirect from execute; flushes in-flight/buffered work
//   redirect_pc     : redirect target, low two bits ignored
//   bus (master)    : imem req/resp channel and decode valid/ready channel
// Optional macro IFETCH_RANGE_CHECK_EN: PCs >= IMEM_BYTES are not sent to
// memory; a NOP entry with if_fault=1 is queued instead.
module instr_fetch_unit
  import ifetch_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int INSTR_W    = DEF_INSTR_W,
  parameter int IMEM_BYTES = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   pc,
  output logic [ADDR_W-1:0]   next_pc,
  input  logic                redirect_valid,
  input  logic [ADDR_W-1:0]   redirect_pc,
  instr_fetch_unit_if.master  bus
);

  fetch_state_t      state, state_n;
  logic [ADDR_W-1:0] req_pc;
  logic [1:0]        q_count;
  logic              q_push, q_head_valid;
  fetch_entry_t      q_din, q_head;
  logic              credit_ok, range_fault, req_fire, fault_push;
  logic              stale_resp;
  logic [1:0]        unused_rpc_lo;

  assign unused_rpc_lo = redirect_pc[1:0];

`ifdef IFETCH_RANGE_CHECK_EN
  assign range_fault = (pc >= ADDR_W'(IMEM_BYTES));
`else
  localparam int unused_imem_bytes = IMEM_BYTES;
  assign range_fault = 1'b0;
`endif

  // Only REQ has nothing outstanding, so count < 2 is the full credit test.
  assign credit_ok = (state == REQ) && (q_count < 2'd2) && !redirect_valid && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= REQ;
      req_pc <= '0;
    end else begin
      state <= state_n;
      if (req_fire) req_pc <= pc;
    end
  end

  always_comb begin
    state_n            = state;
    q_push             = 1'b0;
    q_din              = '0;
    bus.imem_req_valid = 1'b0;
    req_fire           = 1'b0;
    fault_push         = 1'b0;
    case (state)
      REQ: begin
        if (credit_ok) begin
          if (range_fault) begin
            // out-of-range fetch completes locally without a memory access
            fault_push  = 1'b1;
            q_push      = 1'b1;
            q_din.pc    = pc;
            q_din.instr = NOP_INSTR;
`ifdef IFETCH_RANGE_CHECK_EN
            q_din.fault = 1'b1;
`endif
          end else begin
            bus.imem_req_valid = 1'b1;
            if (bus.imem_req_ready) begin
              req_fire = 1'b1;
              state_n  = WAIT;
            end
          end
        end
      end
      WAIT: begin
        if (redirect_valid) begin
          // a response in the redirect cycle is already stale
          state_n = bus.imem_resp_valid ? REQ : DROP;
        end else if (bus.imem_resp_valid) begin
          q_push      = 1'b1;
          q_din.pc    = req_pc;
          q_din.instr = bus.imem_resp_data;
          state_n     = REQ;
        end
      end
      DROP: begin
        if (bus.imem_resp_valid) state_n = REQ;
      end
      default: state_n = REQ;
    endcase
  end

  always_comb begin
    if (rst)                       next_pc = pc;
    else if (redirect_valid)       next_pc = {redirect_pc[ADDR_W-1:2], 2'b00};
    else if (req_fire || fault_push) next_pc = pc + ADDR_W'(4);
    else                           next_pc = pc;
  end

  ifetch_queue u_queue (
    .clk        (clk),
    .rst        (rst),
    .flush      (redirect_valid),
    .push       (q_push),
    .din        (q_din),
    .pop        (bus.if_ready),
    .head_valid (q_head_valid),
    .head       (q_head),
    .count      (q_count)
  );

  assign bus.imem_req_addr = pc;
  assign bus.if_valid      = q_head_valid;
  assign bus.if_pc         = q_head.pc;
  assign bus.if_instr      = q_head.instr;
`ifdef IFETCH_RANGE_CHECK_EN
  assign bus.if_fault      = q_head.fault;
`endif

  // A reset taken while a read is in flight leaves one legitimate late
  // response; remember that so the stray-response check can excuse it.
  always_ff @(posedge clk) begin
    if (rst)                      stale_resp <= stale_resp || (state != REQ);
    else if (bus.imem_resp_valid) stale_resp <= 1'b0;
  end

  a_no_stray_resp: assert property (@(posedge clk) disable iff (rst)
    (bus.imem_resp_valid && (state == REQ)) |-> stale_resp)
    else $error("instr_fetch_unit: imem response with nothing outstanding");

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit. Stimulus pushes hand-computed
// expected memory handshakes {addr, next_pc} and decode entries
// {pc, instr, fault}; monitors pop and compare whenever the DUT shows a
// handshake. Inputs change #1/#2 after posedge, outputs sampled at negedge.
module tb_instr_fetch_unit;
  import ifetch_pkg::*;

  localparam int AW = 32;
  localparam int IW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] pc, next_pc, redirect_pc;
  logic          redirect_valid;

  instr_fetch_unit_if #(.ADDR_W(AW), .INSTR_W(IW)) bus ();

  instr_fetch_unit #(.ADDR_W(AW), .INSTR_W(IW), .IMEM_BYTES(1024)) dut (
    .clk            (clk),
    .rst            (rst),
    .pc             (pc),
    .next_pc        (next_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .bus            (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fault;
  } exp_ent_t;
  typedef struct {
    logic [31:0] addr;
    logic [31:0] npc;
  } exp_hs_t;

  exp_ent_t ent_q[$];
  exp_hs_t  hs_q[$];
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_ent(input logic [31:0] p, input logic [31:0] i, input logic f);
    exp_ent_t e;
    e.pc = p; e.instr = i; e.fault = f;
    ent_q.push_back(e);
  endtask

  task automatic push_hs(input logic [31:0] a, input logic [31:0] n);
    exp_hs_t h;
    h.addr = a; h.npc = n;
    hs_q.push_back(h);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // PC register model, with a one-shot load for test setup
  logic          ld_req = 1'b0;
  logic [AW-1:0] ld_val, nxt;
  initial begin
    pc = '0;
    forever begin
      @(negedge clk);
      nxt = ld_req ? ld_val : next_pc;
      @(posedge clk);
      #1;
      pc = nxt;
    end
  end

  task automatic load_pc(input logic [AW-1:0] v);
    ld_val = v;
    ld_req = 1'b1;
    @(negedge clk);
    #1;
    ld_req = 1'b0;
  endtask

  // Memory model: accepts `grants` requests, answers `lat` cycles later
  // with addr + 0x100.
  int          grants = 0;
  int          lat    = 1;
  int          mcnt   = 0;
  logic        mpend  = 1'b0;
  logic        hs;
  logic [31:0] haddr, maddr;
  initial begin
    bus.imem_req_ready  = 1'b0;
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data  = '0;
    forever begin
      @(negedge clk);
      hs    = bus.imem_req_valid && bus.imem_req_ready;
      haddr = bus.imem_req_addr;
      @(posedge clk);
      #2;
      bus.imem_resp_valid = 1'b0;
      if (hs) begin
        grants--;
        mpend = 1'b1;
        mcnt  = lat;
        maddr = haddr;
      end
      if (mpend) begin
        if (mcnt <= 1) begin
          bus.imem_resp_valid = 1'b1;
          bus.imem_resp_data  = maddr + 32'h100;
          mpend = 1'b0;
        end else begin
          mcnt--;
        end
      end
      bus.imem_req_ready = (grants > 0);
    end
  end

  // Decode-side monitor
  initial begin
    exp_ent_t e;
    forever begin
      @(negedge clk);
      if (!rst && bus.if_valid && bus.if_ready) begin
        if (ent_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_entry: got pc 0x%0h, want no entry", bus.if_pc);
        end else begin
          e = ent_q.pop_front();
          chk("if_pc", bus.if_pc, e.pc);
          chk("if_instr", bus.if_instr, e.instr);
`ifdef IFETCH_RANGE_CHECK_EN
          chk("if_fault", {31'b0, bus.if_fault}, {31'b0, e.fault});
`endif
        end
      end
    end
  end

  // Memory-request monitor
  initial begin
    exp_hs_t h;
    forever begin
      @(negedge clk);
      if (bus.imem_req_valid && bus.imem_req_ready) begin
        if (hs_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_req: got addr 0x%0h, want no request", bus.imem_req_addr);
        end else begin
          h = hs_q.pop_front();
          chk("imem_req_addr", bus.imem_req_addr, h.addr);
          chk("next_pc_on_req", next_pc, h.npc);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    bus.if_ready = 1'b0;

    // Reset: next_pc follows pc even with a redirect pending
    tick;
    load_pc(32'h20);
    tick;
    redirect_valid = 1'b1;
    redirect_pc = 32'h80;
    @(negedge clk);
    chk("rst_next_pc", next_pc, 32'h20);
    chk("rst_req_valid", {31'b0, bus.imem_req_valid}, 32'h0);
    chk("rst_if_valid", {31'b0, bus.if_valid}, 32'h0);
    tick;
    redirect_valid = 1'b0;
    load_pc(32'h0);

    // Streaming, 1-cycle memory
    tick;
    rst = 1'b0;
    grants = 3;
    bus.if_ready = 1'b1;
    push_hs(32'h0, 32'h4); push_hs(32'h4, 32'h8); push_hs(32'h8, 32'hC);
    push_ent(32'h0, 32'h100, 1'b0); push_ent(32'h4, 32'h104, 1'b0); push_ent(32'h8, 32'h108, 1'b0);
    @(negedge clk);
    chk("lat_t0_if_valid", {31'b0, bus.if_valid}, 32'h0);
    tick;
    @(negedge clk);
    chk("lat_t1_if_valid", {31'b0, bus.if_valid}, 32'h0);
    tick;
    @(negedge clk);
    chk("lat_t2_if_valid", {31'b0, bus.if_valid}, 32'h1);
    chk("lat_t2_if_pc", bus.if_pc, 32'h0);
    repeat (10) tick;
    @(negedge clk);
    chk("stall_next_pc_hold", next_pc, 32'hC);

    // Backpressure: queue fills to 2, then drains in order
    tick;
    bus.if_ready = 1'b0;
    grants = 4;
    push_hs(32'hC, 32'h10); push_hs(32'h10, 32'h14); push_hs(32'h14, 32'h18); push_hs(32'h18, 32'h1C);
    push_ent(32'hC, 32'h10C, 1'b0); push_ent(32'h10, 32'h110, 1'b0);
    push_ent(32'h14, 32'h114, 1'b0); push_ent(32'h18, 32'h118, 1'b0);
    repeat (5) tick;
    @(negedge clk);
    chk("full_req_valid", {31'b0, bus.imem_req_valid}, 32'h0);
    chk("full_next_pc_hold", next_pc, 32'h14);
    chk("full_head_pc", bus.if_pc, 32'hC);
    tick;
    bus.if_ready = 1'b1;
    repeat (8) tick;

    // Redirect while WAIT, with a buffered entry to flush
    tick;
    lat = 2;
    grants = 3;
    bus.if_ready = 1'b0;
    push_hs(32'h1C, 32'h20); push_hs(32'h20, 32'h24); push_hs(32'h40, 32'h44);
    push_ent(32'h40, 32'h140, 1'b0);
    repeat (4) tick;
    redirect_valid = 1'b1;
    redirect_pc = 32'h40;
    @(negedge clk);
    chk("wait_redir_next_pc", next_pc, 32'h40);
    chk("wait_redir_req_valid", {31'b0, bus.imem_req_valid}, 32'h0);
    tick;
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("flush_if_valid", {31'b0, bus.if_valid}, 32'h0);
    chk("drop_req_valid", {31'b0, bus.imem_req_valid}, 32'h0);
    tick;
    bus.if_ready = 1'b1;
    repeat (8) tick;

    // Redirect coincident with response, misaligned target
    tick;
    grants = 2;
    push_hs(32'h44, 32'h48); push_hs(32'h40, 32'h44);
    push_ent(32'h40, 32'h140, 1'b0);
    repeat (2) tick;
    redirect_valid = 1'b1;
    redirect_pc = 32'h43;
    @(negedge clk);
    chk("coinc_next_pc", next_pc, 32'h40);
    chk("coinc_req_valid", {31'b0, bus.imem_req_valid}, 32'h0);
    tick;
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("coinc_if_valid", {31'b0, bus.if_valid}, 32'h0);
    chk("coinc_req_addr", bus.imem_req_addr, 32'h40);
    repeat (6) tick;

    // Redirect in REQ suppresses the request that cycle
    tick;
    grants = 1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h80;
    push_hs(32'h80, 32'h84);
    push_ent(32'h80, 32'h180, 1'b0);
    @(negedge clk);
    chk("req_redir_req_valid", {31'b0, bus.imem_req_valid}, 32'h0);
    chk("req_redir_next_pc", next_pc, 32'h80);
    tick;
    redirect_valid = 1'b0;
    repeat (6) tick;

    // Reset with a request outstanding; late response must be ignored
    tick;
    grants = 1;
    lat = 3;
    push_hs(32'h84, 32'h88);
    tick;
    rst = 1'b1;
    tick;
    @(negedge clk);
    chk("rstw_if_valid", {31'b0, bus.if_valid}, 32'h0);
    chk("rstw_req_valid", {31'b0, bus.imem_req_valid}, 32'h0);
    chk("rstw_next_pc", next_pc, 32'h88);
    tick;
    rst = 1'b0;
    tick;
    @(negedge clk);
    chk("late_resp_if_valid", {31'b0, bus.if_valid}, 32'h0);
    tick;
    lat = 1;
    grants = 1;
    push_hs(32'h88, 32'h8C);
    push_ent(32'h88, 32'h188, 1'b0);
    repeat (5) tick;

    // Address at/above IMEM_BYTES
`ifdef IFETCH_RANGE_CHECK_EN
    tick;
    bus.if_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'h400;
    tick;
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("range_req_valid", {31'b0, bus.imem_req_valid}, 32'h0);
    chk("range_next_pc", next_pc, 32'h404);
    tick;
    @(negedge clk);
    chk("range_if_valid", {31'b0, bus.if_valid}, 32'h1);
    chk("range_if_pc", bus.if_pc, 32'h400);
    chk("range_if_instr", bus.if_instr, 32'h13);
    chk("range_if_fault", {31'b0, bus.if_fault}, 32'h1);
    tick;
    redirect_valid = 1'b1;
    redirect_pc = 32'h0;
    tick;
    redirect_valid = 1'b0;
    bus.if_ready = 1'b1;
    repeat (3) tick;
`else
    tick;
    grants = 1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h400;
    push_hs(32'h400, 32'h404);
    push_ent(32'h400, 32'h500, 1'b0);
    tick;
    redirect_valid = 1'b0;
    repeat (5) tick;
`endif

    repeat (2) tick;
    chk("ent_q_drained", ent_q.size(), 32'h0);
    chk("hs_q_drained", hs_q.size(), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
